quotient_checker: RTL and testbench

- Back-multiply unit that runs after the iterative divider.
- It takes a candidate quotient q with its numerator n and denominator d, and computes q*d with a sequential radix-2 shift-add multiplier.
- It compares q*d against n and returns a one-ulp-corrected, truncated quotient plus remainder status flags.
- It turns the divider's approximate result into an exactly truncated result.

---
 rtl/div_pkg.sv | 20 ++
 rtl/quotient_checker_if.sv | 30 +++
 rtl/shift_add_mul.sv | 34 +++
 rtl/quotient_checker.sv | 127 ++++++++++++
 tb/tb_quotient_checker.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the divider back-end: FSM state encoding and
// fixed-point helpers for unsigned Q2.(WIDTH-2) operands.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned WIDTH_DEFAULT = 30;
    localparam int unsigned FRAC_BITS     = WIDTH_DEFAULT - 2;
    localparam logic [WIDTH_DEFAULT-1:0] ONE = WIDTH_DEFAULT'(1) << FRAC_BITS;

    function automatic int unsigned frac_bits(input int unsigned width);
        return width - 2;
    endfunction

endpackage

// File: rtl/quotient_checker_if.sv
// Operand/result handshake bundle for quotient_checker.
interface quotient_checker_if #(
    parameter int unsigned WIDTH = 30
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] numerator;
    logic [WIDTH-1:0] denominator;
    logic [WIDTH-1:0] q_cand;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic             rem_sign;
    logic             corr_up;
    logic             corr_dn;
    logic             exact;
    logic             div_zero;

    modport master (
        output in_valid, numerator, denominator, q_cand, out_ready,
        input  in_ready, out_valid, quotient, rem_sign, corr_up, corr_dn,
               exact, div_zero
    );

    modport slave (
        input  in_valid, numerator, denominator, q_cand, out_ready,
        output in_ready, out_valid, quotient, rem_sign, corr_up, corr_dn,
               exact, div_zero
    );
endinterface

// File: rtl/shift_add_mul.sv
// Sequential radix-2 shift-add multiplier, one multiplier bit per step, LSB first.
module shift_add_mul #(
    parameter int unsigned WIDTH = 30
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               step,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] product,
    output logic               done
);
    localparam int unsigned CW = $clog2(WIDTH);

    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] addend;

    assign addend = {{WIDTH{1'b0}}, multiplicand} << cnt;
    // done flags the step that consumes the final multiplier bit
    assign done   = step && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset || start) begin
            product <= '0;
            cnt     <= '0;
        end else if (step) begin
            if (multiplier[cnt]) begin
                product <= product + addend;
            end
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/quotient_checker.sv
// Back-multiplies a candidate quotient and applies a one-ulp correction so the
// result is the exactly truncated quotient n/d.
module quotient_checker
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 30
) (
    input logic               clk,
    input logic               reset,
    quotient_checker_if.slave bus
);
    localparam int unsigned FB = frac_bits(WIDTH);
    localparam int unsigned RW = 2 * WIDTH + 1;

    state_t             state;
    state_t             state_nx;
    logic [WIDTH-1:0]   n_reg;
    logic [WIDTH-1:0]   d_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [2*WIDTH-1:0] product;
    logic               mul_done;
    logic               accept;

    logic [RW-1:0]      t_ext;
    logic [RW-1:0]      d_ext;
    logic [RW-1:0]      r;
    logic               r_neg;
    logic               r_ge_d;

    logic [WIDTH-1:0]   quot_nx;
    logic               rem_sign_nx;
    logic               corr_up_nx;
    logic               corr_dn_nx;
    logic               exact_nx;
    logic               div_zero_nx;

    assign accept       = (state == IDLE) && bus.in_valid;
    assign bus.in_ready = (state == IDLE);
    assign bus.out_valid = (state == DONE);

    shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk          (clk),
        .reset        (reset),
        .start        (accept),
        .step         (state == MUL),
        .multiplicand (d_reg),
        .multiplier   (q_reg),
        .product      (product),
        .done         (mul_done)
    );

    // Remainder r = n*2^FB - q*d in two's complement; the extra top bit is the sign.
    assign t_ext  = RW'({n_reg, {FB{1'b0}}});
    assign d_ext  = RW'(d_reg);
    assign r      = t_ext - RW'(product);
    assign r_neg  = r[RW-1];
    assign r_ge_d = !r_neg && (r >= d_ext);

    always_comb begin
        quot_nx     = q_reg;
        rem_sign_nx = 1'b0;
        corr_up_nx  = 1'b0;
        corr_dn_nx  = 1'b0;
        exact_nx    = 1'b0;
        div_zero_nx = 1'b0;
        if (d_reg == '0) begin
            quot_nx     = '1;
            div_zero_nx = 1'b1;
        end else if (r_neg) begin
            rem_sign_nx = 1'b1;
            exact_nx    = ((r + d_ext) == '0);
            if (q_reg != '0) begin
                quot_nx    = q_reg - 1'b1;
                corr_dn_nx = 1'b1;
            end
        end else if (r_ge_d) begin
            exact_nx = (r == d_ext);
            if (q_reg != '1) begin
                quot_nx    = q_reg + 1'b1;
                corr_up_nx = 1'b1;
            end
        end else begin
            exact_nx = (r == '0);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nx = MUL;
            MUL:     if (mul_done)      state_nx = CHECK;
            CHECK:                      state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            bus.quotient <= '0;
            bus.rem_sign <= 1'b0;
            bus.corr_up  <= 1'b0;
            bus.corr_dn  <= 1'b0;
            bus.exact    <= 1'b0;
            bus.div_zero <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == CHECK) begin
                bus.quotient <= quot_nx;
                bus.rem_sign <= rem_sign_nx;
                bus.corr_up  <= corr_up_nx;
                bus.corr_dn  <= corr_dn_nx;
                bus.exact    <= exact_nx;
                bus.div_zero <= div_zero_nx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            n_reg <= bus.numerator;
            d_reg <= bus.denominator;
            q_reg <= bus.q_cand;
        end
    end
endmodule

// File: tb/tb_quotient_checker.sv
// Scoreboard bench for quotient_checker at WIDTH=8 (Q2.6 operands).
module tb_quotient_checker;
    localparam int unsigned W   = 8;
    localparam int          ULP = 1 << (W - 2);
    localparam int          LAT = W + 1;

    typedef struct packed {
        logic [W-1:0] quot;
        logic         rs;
        logic         cu;
        logic         cd;
        logic         ex;
        logic         dz;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    quotient_checker_if #(.WIDTH(W)) bus ();
    quotient_checker #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    res_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    time    accept_t;

    function automatic res_t model(input int n, input int d, input int q);
        res_t e;
        int   r;
        e = '0;
        if (d == 0) begin
            e.quot = '1;
            e.dz   = 1'b1;
            return e;
        end
        r = n * ULP - q * d;
        e.quot = W'(q);
        if (r < 0) begin
            e.rs = 1'b1;
            e.ex = (r + d == 0);
            if (q != 0) begin
                e.quot = W'(q - 1);
                e.cd   = 1'b1;
            end
        end else if (r >= d) begin
            e.ex = (r == d);
            if (q != (1 << W) - 1) begin
                e.quot = W'(q + 1);
                e.cu   = 1'b1;
            end
        end else begin
            e.ex = (r == 0);
        end
        return e;
    endfunction

    function automatic res_t observed();
        return {bus.quotient, bus.rem_sign, bus.corr_up, bus.corr_dn, bus.exact, bus.div_zero};
    endfunction

    task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] d,
                          input logic [W-1:0] q, input res_t want, input int hold);
        res_t got;
        res_t exp_r;
        int   lat;
        bit   ok;
        @(negedge clk);
        bus.numerator   = n;
        bus.denominator = d;
        bus.q_cand      = q;
        bus.in_valid    = 1'b1;
        sb.push_back(want);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.in_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk);
        accept_t = $time;
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        ok  = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.out_valid) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (!ok || lat != LAT) begin
            errors++;
            $display("FAIL latency: got %0d cycles (valid=%b) required %0d", lat, ok, LAT);
        end
        exp_r = sb.pop_front();
        if (!ok) return;
        got = observed();
        checks++;
        if (got.quot !== exp_r.quot) begin
            errors++;
            $display("FAIL quotient n=%h d=%h q=%h: got %h required %h", n, d, q, got.quot, exp_r.quot);
        end
        checks++;
        if (got[4:0] !== exp_r[4:0]) begin
            errors++;
            $display("FAIL flags n=%h d=%h q=%h: got rs/cu/cd/ex/dz=%b required %b",
                     n, d, q, got[4:0], exp_r[4:0]);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (observed() !== got || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold cycle %0d: got res=%h valid=%b ready=%b required res=%h valid=1 ready=0",
                         i, observed(), bus.out_valid, bus.in_ready, got);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release: got valid=%b ready=%b required valid=0 ready=1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || observed() !== '0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b valid=%b res=%h required ready=1 valid=0 res=0",
                     bus.in_ready, bus.out_valid, observed());
        end
        reset = 1'b0;
    endtask

    task automatic test_vectors();
        run_op(8'h40, 8'h40, 8'h40, '{8'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}, 0);
        run_op(8'h40, 8'h60, 8'h2B, '{8'h2A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}, 0);
        run_op(8'h40, 8'h60, 8'h29, '{8'h2A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, 0);
        run_op(8'h40, 8'h00, 8'h12, '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}, 0);
    endtask

    task automatic test_boundaries();
        run_op(8'h00, 8'h40, 8'h00, '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}, 0);
        // r = 0xFF*64 - 0xFF*0x20 = 8160 >= 32: saturates instead of wrapping
        run_op(8'hFF, 8'h20, 8'hFF, '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 0);
        run_op(8'h01, 8'hC0, 8'h00, '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 0);
    endtask

    task automatic test_hold();
        run_op(8'h30, 8'h50, 8'h26, model(8'h30, 8'h50, 8'h26), 5);
    endtask

    task automatic test_back_to_back();
        time t0;
        run_op(8'h20, 8'h40, 8'h21, model(8'h20, 8'h40, 8'h21), 0);
        t0 = accept_t;
        run_op(8'h7F, 8'h55, 8'h5F, model(8'h7F, 8'h55, 8'h5F), 0);
        checks++;
        if (accept_t - t0 != (W + 3) * 10) begin
            errors++;
            $display("FAIL init_interval: got %0t required %0d", accept_t - t0, (W + 3) * 10);
        end
    endtask

    task automatic test_random();
        int done_ops = 0;
        for (int t = 0; t < 200 && done_ops < 16; t++) begin
            int qt, d, n, qx, q;
            qt = $urandom_range(0, 255);
            d  = $urandom_range(1, 255);
            n  = (qt * d) / ULP + $urandom_range(0, 2);
            if (n > 255) continue;
            qx = (n * ULP) / d;
            if (qx > 255) continue;
            q = qx + $urandom_range(0, 2) - 1;
            if (q < 0) q = 0;
            if (q > 255) q = 255;
            run_op(W'(n), W'(d), W'(q), model(n, d, q), 0);
            done_ops++;
        end
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        @(negedge clk);
        bus.numerator   = 8'h40;
        bus.denominator = 8'h60;
        bus.q_cand      = 8'h2B;
        bus.in_valid    = 1'b1;
        sb.push_back(model(8'h40, 8'h60, 8'h2B));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || observed() !== '0) begin
            errors++;
            $display("FAIL mid_reset: got ready=%b valid=%b res=%h required ready=1 valid=0 res=0",
                     bus.in_ready, bus.out_valid, observed());
        end
        seen = 0;
        for (int i = 0; i < 2 * LAT; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL aborted_result: got out_valid=1 required 0");
        end
        run_op(8'h40, 8'h60, 8'h29, '{8'h2A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, 0);
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.numerator   = '0;
        bus.denominator = '0;
        bus.q_cand      = '0;
        test_reset();
        test_vectors();
        test_boundaries();
        test_hold();
        test_back_to_back();
        test_random();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
